// File: rtl/layer_draw_scheduler.sv
// layer_draw_scheduler: frame-level sequencer for the layer drawing engines.
// Walks enabled layers in ascending order (LOAD -> DRAW -> DRAIN), drives the
// framebuffer write pipeline and reports frame completion.
// Optional feature macro: DRAW_SCHED_TIMEOUT_EN (per-layer DRAW cycle limit).
module layer_draw_scheduler #(
  parameter int unsigned NUM_LAYERS     = 4,
  parameter int unsigned LAYER_W        = 3,
  parameter int unsigned DRAIN_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 76800
) (
  input  logic                  CLK,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  frame_start,
  input  logic [NUM_LAYERS-1:0] layer_mask,
  input  logic [NUM_LAYERS-1:0] layer_end,
  output logic [NUM_LAYERS-1:0] layer_rst,
  output logic [NUM_LAYERS-1:0] cur_state,
  output logic [LAYER_W-1:0]    layer_sel,
  output logic [LAYER_W-1:0]    wr_layer_sel,
  output logic                  vram_we,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  frame_overrun,
  output logic                  timeout_err
);

  localparam int unsigned DC_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAW, S_DRAIN, S_DONE} state_t;

  state_t                 state_q, state_nx;
  logic [NUM_LAYERS-1:0]  mask_q, mask_nx;
  logic [LAYER_W-1:0]     sel_q, sel_nx;
  logic [DC_W-1:0]        drain_q, drain_nx;
  logic [NUM_LAYERS-1:0]  rst_q, rst_nx, cur_q, cur_nx;
  logic                   busy_q, busy_nx, done_q, done_nx, ovr_q, ovr_nx;
  logic                   we_in, accept, cur_end, to_hit, draw_exit;
  logic                   low_found, high_found;
  logic [LAYER_W-1:0]     low_idx, high_idx;
  logic [NUM_LAYERS-1:0]  sel_oh, sel_nx_oh;
  logic [DRAIN_CYCLES-1:0]              pipe_we;
  logic [DRAIN_CYCLES-1:0][LAYER_W-1:0] pipe_sel;

  assign accept    = frame_start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign sel_oh    = NUM_LAYERS'(1) << sel_q;
  assign sel_nx_oh = NUM_LAYERS'(1) << sel_nx;
  assign cur_end   = |(layer_end & sel_oh);
  assign draw_exit = cur_end | to_hit;

  // Priority encoders: first layer of a new frame, next layer above current
  always_comb begin
    low_found  = 1'b0;
    low_idx    = '0;
    high_found = 1'b0;
    high_idx   = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (!low_found && layer_mask[i]) begin
        low_found = 1'b1;
        low_idx   = LAYER_W'(i);
      end
      if (!high_found && mask_q[i] && (LAYER_W'(i) > sel_q)) begin
        high_found = 1'b1;
        high_idx   = LAYER_W'(i);
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nx = state_q;
    mask_nx  = mask_q;
    sel_nx   = sel_q;
    drain_nx = drain_q;
    we_in    = 1'b0;
    ovr_nx   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_nx = S_IDLE;
        if (frame_start) begin
          mask_nx = layer_mask;
          if (low_found) begin
            sel_nx   = low_idx;
            state_nx = S_LOAD;
          end else begin
            state_nx = S_DONE;
          end
        end
      end
      S_LOAD: begin
        ovr_nx   = frame_start;
        state_nx = S_DRAW;
      end
      S_DRAW: begin
        ovr_nx = frame_start;
        if (draw_exit) begin
          state_nx = S_DRAIN;
          drain_nx = '0;
        end else begin
          we_in = 1'b1;
        end
      end
      S_DRAIN: begin
        ovr_nx = frame_start;
        if (drain_q == DC_W'(DRAIN_CYCLES - 1)) begin
          if (high_found) begin
            sel_nx   = high_idx;
            state_nx = S_LOAD;
          end else begin
            state_nx = S_DONE;
          end
        end else begin
          drain_nx = drain_q + DC_W'(1);
        end
      end
      default: state_nx = S_IDLE;
    endcase
    rst_nx  = (state_nx == S_LOAD) ? sel_nx_oh : '0;
    cur_nx  = (state_nx == S_DRAW) ? sel_nx_oh : '0;
    busy_nx = (state_nx != S_IDLE);
    done_nx = (state_nx == S_DONE);
  end

  // State, output and write-pipeline registers; everything holds while ena=0
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mask_q   <= '0;
      sel_q    <= '0;
      drain_q  <= '0;
      rst_q    <= '0;
      cur_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
      pipe_we  <= '0;
      pipe_sel <= '0;
    end else if (ena) begin
      state_q     <= state_nx;
      mask_q      <= mask_nx;
      sel_q       <= sel_nx;
      drain_q     <= drain_nx;
      rst_q       <= rst_nx;
      cur_q       <= cur_nx;
      busy_q      <= busy_nx;
      done_q      <= done_nx;
      ovr_q       <= ovr_nx;
      pipe_we[0]  <= we_in;
      pipe_sel[0] <= sel_q;
      for (int i = 1; i < DRAIN_CYCLES; i++) begin
        pipe_we[i]  <= pipe_we[i-1];
        pipe_sel[i] <= pipe_sel[i-1];
      end
    end
  end

`ifdef DRAW_SCHED_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q;
  logic            terr_q;

  assign to_hit = (to_cnt_q == TO_W'(TIMEOUT_CYCLES));

  // Per-layer DRAW cycle counter and sticky timeout flag
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
      terr_q   <= 1'b0;
    end else if (ena) begin
      if (state_q == S_LOAD) begin
        to_cnt_q <= '0;
      end else if ((state_q == S_DRAW) && !to_hit) begin
        to_cnt_q <= to_cnt_q + TO_W'(1);
      end
      if (accept) begin
        terr_q <= 1'b0;
      end else if ((state_q == S_DRAW) && to_hit && !cur_end) begin
        terr_q <= 1'b1;
      end
    end
  end

  assign timeout_err = terr_q;
`else
  assign to_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Pulse-type outputs are suppressed on disabled cycles and re-emit later
  assign layer_rst     = rst_q & {NUM_LAYERS{ena}};
  assign frame_done    = done_q & ena;
  assign vram_we       = pipe_we[DRAIN_CYCLES-1] & ena;
  assign wr_layer_sel  = pipe_sel[DRAIN_CYCLES-1];
  assign cur_state     = cur_q;
  assign layer_sel     = sel_q;
  assign busy          = busy_q;
  assign frame_overrun = ovr_q;

endmodule

// File: tb/tb_layer_draw_scheduler.sv
// Testbench for layer_draw_scheduler: 4x2-pixel engine models, scoreboard of
// expected write layers and layer_rst order. Set DRAW_SCHED_TIMEOUT_EN to also
// exercise the layer timeout (TIMEOUT_CYCLES = 10).
module tb_layer_draw_scheduler;

  localparam int unsigned NL = 4;
  localparam int unsigned LW = 3;
  localparam int unsigned DC = 2;
  localparam int unsigned TO = 10;
  localparam int unsigned WH = 8;
  localparam int LAYER_COST = 1 + (WH + 1) + DC;

  logic          CLK, rst_n, ena, frame_start;
  logic [NL-1:0] layer_mask, layer_end, layer_rst, cur_state;
  logic [LW-1:0] layer_sel, wr_layer_sel;
  logic          vram_we, busy, frame_done, frame_overrun, timeout_err;

  layer_draw_scheduler #(
    .NUM_LAYERS(NL), .LAYER_W(LW), .DRAIN_CYCLES(DC), .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK(CLK), .rst_n(rst_n), .ena(ena), .frame_start(frame_start),
    .layer_mask(layer_mask), .layer_end(layer_end), .layer_rst(layer_rst),
    .cur_state(cur_state), .layer_sel(layer_sel), .wr_layer_sel(wr_layer_sel),
    .vram_we(vram_we), .busy(busy), .frame_done(frame_done),
    .frame_overrun(frame_overrun), .timeout_err(timeout_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ovr_seen = 0;
  logic [NL-1:0] cur_mask = '0;
  bit stuck0 = 1'b0;
  int unsigned wr_q[$];
  int unsigned rst_q[$];
  logic [3:0] pix_cnt [NL];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // Engine models: pixel walker reset by layer_rst, advances while active
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NL; i++) pix_cnt[i] <= '0;
    end else if (ena) begin
      for (int i = 0; i < NL; i++) begin
        if (layer_rst[i]) pix_cnt[i] <= '0;
        else if (cur_state[i] && (pix_cnt[i] < 4'(WH))) pix_cnt[i] <= pix_cnt[i] + 4'd1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NL; i++)
      layer_end[i] = (pix_cnt[i] >= 4'(WH)) && !(stuck0 && (i == 0));
  end

  // Output monitor: pops the scoreboard on every write and layer reset
  always @(negedge CLK) begin
    if (rst_n) begin
      if (vram_we) begin
        check_eq("we_ena", ena, 1);
        check_eq("wr_q_nonempty", wr_q.size() != 0, 1);
        if (wr_q.size() != 0) check_eq("wr_sel", wr_layer_sel, wr_q.pop_front());
      end
      if (layer_rst != '0) begin
        check_eq("rst_q_nonempty", rst_q.size() != 0, 1);
        if (rst_q.size() != 0) check_eq("rst_order", layer_rst, 32'd1 << rst_q.pop_front());
      end
      if (cur_state != '0) begin
        check_eq("cur_onehot", $onehot(cur_state), 1);
        check_eq("cur_masked", cur_state & ~cur_mask, 0);
      end
      if (!ena) check_eq("ena_low_pulses", {vram_we, |layer_rst, frame_done}, 0);
      if (frame_overrun) ovr_seen++;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic push_exp(input logic [NL-1:0] mask);
    cur_mask = mask;
    for (int i = 0; i < NL; i++) begin
      if (mask[i]) begin
        rst_q.push_back(i);
        repeat ((stuck0 && i == 0) ? TO : WH) wr_q.push_back(i);
      end
    end
  endtask

  // Waits (bounded) for frame_done, optionally toggling ena or injecting an overrun
  task automatic wait_done(input int acc, input bit tog, input bit ovr, input int exp_lat);
    bit seen = 1'b0, armed = 1'b0, sent = 1'b0;
    int lat = -1;
    for (int k = 0; k < 2000 && !seen; k++) begin
      @(negedge CLK);
      if (frame_done) begin
        seen = 1'b1;
        lat  = cyc - acc;
      end else begin
        if (ovr && cur_state[1]) armed = 1'b1;
        @(posedge CLK);
        #2;
        if (armed && !sent) begin
          frame_start = 1'b1;
          sent = 1'b1;
        end else begin
          frame_start = 1'b0;
        end
        if (tog) ena = ~ena;
      end
    end
    frame_start = 1'b0;
    ena = 1'b1;
    check_eq("done_seen", seen, 1);
    if (exp_lat >= 0) check_eq("done_lat", lat, exp_lat);
    check_eq("wr_drained", wr_q.size(), 0);
    check_eq("rst_drained", rst_q.size(), 0);
  endtask

  task automatic start_frame(input logic [NL-1:0] mask, output int acc);
    push_exp(mask);
    layer_mask  = mask;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    acc = cyc;
  endtask

  function automatic int cost(input logic [NL-1:0] mask);
    return $countones(mask) * LAYER_COST;
  endfunction

  initial begin
    int acc;
    bit got;
    rst_n = 1'b0; ena = 1'b1; frame_start = 1'b0; layer_mask = '0;
    repeat (2) @(negedge CLK);
    check_eq("rst_out", {layer_rst, cur_state, layer_sel, wr_layer_sel, vram_we, busy,
                         frame_done, frame_overrun, timeout_err}, 0);
    rst_n = 1'b1;
    tick();
    check_eq("idle_busy", busy, 0);

    // Full mask, then back-to-back frame accepted in DONE
    start_frame(4'b1111, acc);
    check_eq("busy_run", busy, 1);
    wait_done(acc, 1'b0, 1'b0, cost(4'b1111));
    push_exp(4'b0101);
    layer_mask  = 4'b0101;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    acc = cyc;
    check_eq("b2b_busy", busy, 1);
    check_eq("b2b_load", layer_rst, 4'b0001);
    wait_done(acc, 1'b0, 1'b0, cost(4'b0101));
    tick();
    tick();
    check_eq("idle_after", busy, 0);

    // Empty mask
    start_frame(4'b0000, acc);
    wait_done(acc, 1'b0, 1'b0, 0);
    tick();

    // Overrun during layer 1 DRAW
    ovr_seen = 0;
    start_frame(4'b1111, acc);
    wait_done(acc, 1'b0, 1'b1, cost(4'b1111));
    check_eq("ovr_pulses", ovr_seen, 1);
    tick();

    // ena toggling every cycle
    start_frame(4'b1011, acc);
    wait_done(acc, 1'b1, 1'b0, -1);
    tick();

    // Asynchronous reset mid-DRAW
    start_frame(4'b1111, acc);
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge CLK);
      got = (cur_state != '0);
    end
    check_eq("draw_reached", got, 1);
    #1 rst_n = 1'b0;
    #1 check_eq("arst_out", {layer_rst, cur_state, layer_sel, wr_layer_sel, vram_we, busy,
                             frame_done, frame_overrun, timeout_err}, 0);
    wr_q.delete();
    rst_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    start_frame(4'b0110, acc);
    wait_done(acc, 1'b0, 1'b0, cost(4'b0110));
    tick();

`ifdef DRAW_SCHED_TIMEOUT_EN
    // Layer 0 never ends: TO writes, then timeout_err and layer 1 proceeds
    stuck0 = 1'b1;
    start_frame(4'b0011, acc);
    wait_done(acc, 1'b0, 1'b0, (1 + TO + 1 + DC) + LAYER_COST);
    check_eq("timeout_set", timeout_err, 1);
    stuck0 = 1'b0;
    tick();
    start_frame(4'b0001, acc);
    check_eq("timeout_clr", timeout_err, 0);
    wait_done(acc, 1'b0, 1'b0, cost(4'b0001));
`else
    check_eq("timeout_tied", timeout_err, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
